uart_rx_fifo: RTL and testbench

//  Receive buffer that sits directly downstream of the UART receiver on the same 24 MHz clock.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
// Entry width grows to carry the parity flag when UART_RX_FIFO_PERR_EN is defined.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ACK,
    RX_WAIT
  } rx_state_e;

`ifdef UART_RX_FIFO_PERR_EN
  localparam int ENTRY_W = UART_DW + 1;
`else
  localparam int ENTRY_W = UART_DW;
`endif

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO.
// Synchronous write, asynchronous read so the head entry is visible without a read cycle.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per rdrf frame, acknowledges it, and queues it in a FWFT FIFO.
// Optional feature macro: UART_RX_FIFO_PERR_EN stores the parity flag alongside each byte.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               rdrf,
  input  logic [UART_DW-1:0] rx_data,
  input  logic               prty_err,
  output logic               rdrf_clr,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               rd_perr,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count,
  output logic               overrun,
  input  logic               ovr_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rx_state_e          state_q, state_d;
  logic               capture;
  logic               push, pop, drop;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overrun_q, overrun_d;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  // WAIT holds off re-capture until the receiver drops rdrf, so a lingering flag yields one push.
  always_comb begin
    state_d  = state_q;
    rdrf_clr = 1'b1;
    capture  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rdrf) begin
          capture = 1'b1;
          state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        rdrf_clr = 1'b0;
        state_d  = RX_WAIT;
      end
      RX_WAIT: begin
        if (!rdrf) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A full FIFO still accepts a byte when the CPU pops in the same cycle.
  always_comb begin
    pop       = rd_en && (count_q != '0);
    push      = capture && ((count_q != FULL_CNT) || rd_en);
    drop      = capture && !push;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    overrun_d = drop | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= RX_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_entry)
  );

`ifdef UART_RX_FIFO_PERR_EN
  assign wr_entry = {prty_err, rx_data};
  assign rd_perr  = empty ? 1'b0 : rd_entry[ENTRY_W-1];
`else
  logic unused_prty_err;
  assign unused_prty_err = prty_err;
  assign wr_entry        = rx_data;
  assign rd_perr         = 1'b0;
`endif

  assign rd_data = empty ? '0 : rd_entry[UART_DW-1:0];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using a queue scoreboard of {perr, byte} entries.
// Define UART_RX_FIFO_PERR_EN for both bench and RTL to exercise the parity-flag path.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       clr;
  logic       rdrf;
  logic [7:0] rx_data;
  logic       prty_err;
  logic       rdrf_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [8:0] expQ[$];
  logic       expOverrun  = 1'b0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .rdrf     (rdrf),
    .rx_data  (rx_data),
    .prty_err (prty_err),
    .rdrf_clr (rdrf_clr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expPerr(input logic [8:0] e);
`ifdef UART_RX_FIFO_PERR_EN
    return e[8];
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'(expQ.size()));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(expQ.size() == 0));
    checkOutput({tag, "_full"}, 32'(full), 32'(expQ.size() == 16));
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'(expOverrun));
    if (expQ.size() == 0) begin
      checkOutput({tag, "_rd_data_empty"}, 32'(rd_data), 32'h0);
    end else begin
      checkOutput({tag, "_rd_data_head"}, 32'(rd_data), 32'(expQ[0][7:0]));
      checkOutput({tag, "_rd_perr_head"}, 32'(rd_perr), 32'(expPerr(expQ[0])));
    end
  endtask

  // One receiver frame: rdrf held for holdCycles, single ack pulse expected right after capture.
  task automatic applyStimulus(input logic [7:0] b, input logic perr, input int holdCycles);
    rdrf     = 1'b1;
    rx_data  = b;
    prty_err = perr;
    tick();
    if (expQ.size() < 16) expQ.push_back({perr, b});
    else expOverrun = 1'b1;
    checkOutput("ack_low", 32'(rdrf_clr), 32'h0);
    for (int i = 1; i < holdCycles; i++) begin
      tick();
      checkOutput("ack_idle_while_held", 32'(rdrf_clr), 32'h1);
    end
    rdrf = 1'b0;
    tick();
    checkOutput("ack_released", 32'(rdrf_clr), 32'h1);
    tick();
  endtask

  task automatic popByte();
    logic [8:0] e;
    if (expQ.size() == 0) begin
      checkOutput("pop_model_nonempty", 32'(expQ.size()), 32'h1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("pop_rd_data", 32'(rd_data), 32'(e[7:0]));
    checkOutput("pop_rd_perr", 32'(rd_perr), 32'(expPerr(e)));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    clr = 1'b1; rdrf = 1'b0; rx_data = 8'h00; prty_err = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    tick();
    tick();
    checkOutput("reset_rdrf_clr", 32'(rdrf_clr), 32'h1);
    checkStatus("reset");
    clr = 1'b0;
    tick();

    $display("[TB] single byte");
    applyStimulus(8'hA5, 1'b0, 1);
    checkStatus("single");
    popByte();
    checkStatus("single_drained");

    $display("[TB] lingering rdrf");
    applyStimulus(8'h3C, 1'b0, 10);
    checkStatus("linger");
    popByte();

    $display("[TB] fill and overrun");
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0, 1);
    checkStatus("filled");
    applyStimulus(8'hFF, 1'b0, 1);
    checkStatus("overrun_set");
    ovr_clr = 1'b1;
    tick();
    ovr_clr   = 1'b0;
    expOverrun = 1'b0;
    checkStatus("overrun_cleared");

    // Drop and clear in the same cycle: the new overrun must win.
    rdrf = 1'b1; rx_data = 8'hEE; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0; rdrf = 1'b0;
    expOverrun = 1'b1;
    checkOutput("set_beats_clear", 32'(overrun), 32'h1);
    tick();
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    expOverrun = 1'b0;
    checkStatus("overrun_recleared");

    $display("[TB] push while full with pop");
    rdrf = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
    checkOutput("full_pop_head", 32'(rd_data), 32'(expQ[0][7:0]));
    tick();
    void'(expQ.pop_front());
    expQ.push_back({1'b0, 8'h55});
    rd_en = 1'b0;
    checkOutput("full_pop_ack", 32'(rdrf_clr), 32'h0);
    rdrf = 1'b0;
    tick();
    tick();
    checkStatus("full_pop");
    while (expQ.size() > 0) popByte();
    checkStatus("drained");

    $display("[TB] pointer wrap");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'((i * 37 + 11) & 8'hFF), 1'b0, 1);
      checkOutput("wrap_not_empty", 32'(empty), 32'h0);
      popByte();
    end
    checkStatus("wrap_end");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checkStatus("pop_on_empty");

`ifdef UART_RX_FIFO_PERR_EN
    $display("[TB] parity flag");
    applyStimulus(8'h77, 1'b1, 1);
    applyStimulus(8'h78, 1'b0, 1);
    checkOutput("perr_head_set", 32'(rd_perr), 32'h1);
    popByte();
    checkOutput("perr_next_clear", 32'(rd_perr), 32'h0);
    popByte();
    checkStatus("perr_done");
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(8'h10, 1'b0, 1);
    applyStimulus(8'h11, 1'b0, 1);
    rdrf = 1'b1; rx_data = 8'h12;
    tick();
    expQ.push_back({1'b0, 8'h12});
    tick();
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    #2;
    clr = 1'b1;
    #1;
    expQ.delete();
    expOverrun = 1'b0;
    checkOutput("midreset_rdrf_clr", 32'(rdrf_clr), 32'h1);
    checkStatus("midreset");
    #3;
    clr = 1'b0;
    tick();
    expQ.push_back({1'b0, 8'h12});
    checkOutput("recapture_ack", 32'(rdrf_clr), 32'h0);
    checkStatus("recapture");
    rdrf = 1'b0;
    tick();
    tick();
    popByte();
    checkStatus("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
